uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 435, sys_clk cycles per serial bit (435 = 230400 baud at 100 MHz); legal range 8..16383.
REQ-002 SHALL have port: sys_clk  input  1  the single clock; all flops on rising edge.
REQ-003 SHALL have port: uart_reset_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: RxD  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port: rd  input  1  consumer acknowledge; clears valid.
REQ-006 SHALL have port: data  output  8  last correctly received byte.
REQ-007 SHALL have port: valid  output  1  level; data holds an unread byte.
REQ-008 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port: frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 SHALL have port: overrun  output  1  one-cycle pulse when a byte completes while valid is high.
REQ-011 SHALL have port: parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without the macro.

Function
REQ-012 SHALL pass RxD through a 2-flop synchronizer reset to 1; all decisions use the synchronized value (2-cycle input latency).
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK; a 14-bit bit-timer and a 3-bit bit index.
REQ-014 IDLE: on synchronized RxD = 0 SHALL enter START with timer cleared.
REQ-015 START: at timer = CLKS_PER_BIT/2 - 1 (integer division) SHALL sample; 0 -> DATA with timer cleared; 1 -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: SHALL sample at timer = CLKS_PER_BIT - 1, shift the bit in LSB first, clear the timer; after the 8th bit -> PARITY if macro defined, else STOP.
REQ-017 PARITY: SHALL sample one bit period later and compare with even parity of the 8 data bits; mismatch is recorded and the FSM proceeds to STOP.
REQ-018 STOP: SHALL sample one bit period later; 1 and no recorded parity error -> data updated, valid set, -> IDLE; 1 with parity error -> parity_err pulse, data/valid unchanged, -> IDLE; 0 -> frame_err pulse, data/valid unchanged, -> BREAK.
REQ-019 BREAK: SHALL remain until synchronized RxD = 1, then -> IDLE; no new start is detected while in BREAK.
REQ-020 Valid byte completion while valid = 1 SHALL overwrite data, keep valid = 1, and pulse overrun.
REQ-021 rd with valid = 1 SHALL clear valid next cycle; rd with valid = 0 SHALL be ignored; rd in the same cycle as a byte completion SHALL leave valid = 1 with the new byte and no overrun.
REQ-022 A byte SHALL be reported as valid exactly 1 clock after the stop-bit sample cycle.
REQ-023 The timer SHALL never wrap; it is cleared at every sample point and on every transition into START.

Reset
REQ-024 On uart_reset_n low SHALL immediately force: state IDLE, timer 0, bit index 0, shift register 0, data 8'h00, valid 0, busy 0, frame_err 0, overrun 0, parity_err 0, synchronizer flops 1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release the block waits for a fresh high-to-low edge (a line held low SHALL produce START then, on high sample, IDLE; or on low sample a full frame attempt).

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: frame is start + 8 data + even parity + stop (11 bits), PARITY state and parity_err active.
REQ-027 Macro UART_RX_PARITY_EN undefined: frame is start + 8 data + stop (10 bits), PARITY state absent, parity_err tied 0.

Verification
REQ-028 Send 8'h55 with CLKS_PER_BIT=435, good stop -> valid rises once, data = 8'h55, frame_err/overrun = 0.
REQ-029 Send 8'hA3, pulse rd, send 8'h3C -> data 8'hA3 then 8'h3C, valid cleared between bytes, no overrun.
REQ-030 Drive RxD low for 100 cycles then high -> no valid, busy returns 0, state IDLE.
REQ-031 Send 8'hF0 with stop bit 0 held low 3 bit periods -> frame_err one pulse, data unchanged, no restart until RxD high.
REQ-032 Send 8'h11 and 8'h22 without rd -> overrun pulses once, data = 8'h22, valid = 1.
REQ-033 Assert uart_reset_n low during bit 4 of 8'hC7, release, send 8'h81 -> only 8'h81 reported; with UART_RX_PARITY_EN, 8'h81 with odd parity bit -> parity_err pulse, valid unchanged.

Source files
------------

// File: rtl/uart_rx.sv
// Serial byte receiver with 8N1 framing, or 8E1 when UART_RX_PARITY_EN is defined.
// Latency: 2-cycle RxD synchronizer; valid rises 1 clock after the stop-bit sample.
// Backpressure: none; an unread byte is overwritten and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 435
) (
  input  logic       sys_clk,
  input  logic       uart_reset_n,
  input  logic       RxD,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  localparam logic [13:0] BIT_LAST  = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] HALF_LAST = 14'(CLKS_PER_BIT / 2 - 1);

  logic        rx_meta;
  logic        rx_sync;
  logic [2:0]  state;
  logic [13:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        bit_done;
  logic        half_done;
  logic        par_bad;
  logic        stop_sample;
  logic        byte_ok;

  always_ff @(posedge sys_clk or negedge uart_reset_n) begin
    if (!uart_reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rx_sync <= rx_meta;
    end
  end

  assign bit_done    = (timer == BIT_LAST);
  assign half_done   = (timer == HALF_LAST);
  assign stop_sample = (state == ST_STOP) && bit_done;
  assign busy        = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_flag;
  logic perr_q;

  // The parity verdict is held until the stop bit decides whether it matters.
  always_ff @(posedge sys_clk or negedge uart_reset_n) begin
    if (!uart_reset_n) begin
      par_flag <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      perr_q <= stop_sample && rx_sync && par_flag;
      if ((state == ST_PARITY) && bit_done) begin
        par_flag <= (rx_sync != ^shreg);
      end
    end
  end

  assign par_bad    = par_flag;
  assign parity_err = perr_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign byte_ok = stop_sample && rx_sync && !par_bad;

  always_ff @(posedge sys_clk or negedge uart_reset_n) begin
    if (!uart_reset_n) begin
      state   <= ST_IDLE;
      timer   <= 14'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          timer <= 14'd0;
          if (!rx_sync) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (half_done) begin
            timer   <= 14'd0;
            bit_idx <= 3'd0;
            state   <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            timer <= timer + 14'd1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            timer   <= 14'd0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            timer <= timer + 14'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            timer <= 14'd0;
            state <= ST_STOP;
          end else begin
            timer <= timer + 14'd1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_done) begin
            timer <= 14'd0;
            state <= rx_sync ? ST_IDLE : ST_BREAK;
          end else begin
            timer <= timer + 14'd1;
          end
        end
        ST_BREAK: begin
          // A held-low line must go idle before a new start bit can count.
          timer <= 14'd0;
          if (rx_sync) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= 14'd0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge uart_reset_n) begin
    if (!uart_reset_n) begin
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_sample && !rx_sync;
      overrun   <= 1'b0;
      if (byte_ok) begin
        // A same-cycle rd consumes the old byte, so nothing is lost.
        data    <= shreg;
        valid   <= 1'b1;
        overrun <= valid && !rd;
      end else if (rd && valid) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
